// File: rtl/desc_sample_scan_pkg.sv
// Shared widths, window geometry, FSM states and sample payload for the descriptor sample scanner.
package desc_sample_scan_pkg;

   localparam int unsigned COORD_W = 11;
   localparam int unsigned OFF_W   = 5;
   localparam int unsigned KP_W    = 10;
   localparam int unsigned WIN_N   = 256;
   localparam int unsigned IDX_W   = 8;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One registered sample: coordinates, window position and flags.
   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic [IDX_W-1:0]          idx;
      logic                      oob;
      logic                      last;
   } sample_t;

endpackage

// File: rtl/desc_coord_add.sv
// One axis: zero-extended keypoint plus sign-extended offset, with image bound test.
module desc_coord_add
   import desc_sample_scan_pkg::*;
#(
   parameter int unsigned LIMIT = 640
) (
   input  logic        [KP_W-1:0]    kp,
   input  logic signed [OFF_W-1:0]   off,
   output logic signed [COORD_W-1:0] sum_c,
   output logic                      oob_c
);

   logic signed [COORD_W-1:0] kp_ext;
   logic signed [COORD_W-1:0] off_ext;

   // Extend both operands to the coordinate width; the sum wraps without saturation.
   assign kp_ext  = COORD_W'(kp);
   assign off_ext = {{(COORD_W-OFF_W){off[OFF_W-1]}}, off};
   assign sum_c   = kp_ext + off_ext;

   // Outside when negative or at/after the image edge.
   assign oob_c = sum_c[COORD_W-1] || (sum_c >= $signed(COORD_W'(LIMIT)));

endmodule

// File: rtl/desc_sample_scan.sv
// Walks the 256 positions of one keypoint window, emitting offset sample coordinates.
module desc_sample_scan
   import desc_sample_scan_pkg::*;
#(
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic        [KP_W-1:0]    kp_x,
   input  logic        [KP_W-1:0]    kp_y,
   output logic                      busy,
   output logic        [IDX_W-1:0]   rom_a,
   input  logic signed [OFF_W-1:0]   rom_x_spo,
   input  logic signed [OFF_W-1:0]   rom_y_spo,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [COORD_W-1:0] out_x,
   output logic signed [COORD_W-1:0] out_y,
   output logic        [IDX_W-1:0]   out_idx,
   output logic                      out_oob,
   output logic                      out_last,
   output logic                      done
);

   state_t                    state;
   logic [IDX_W-1:0]          cnt;
   logic [KP_W-1:0]           kx;
   logic [KP_W-1:0]           ky;
   sample_t                   smp_q;
   logic signed [COORD_W-1:0] sx_c;
   logic signed [COORD_W-1:0] sy_c;
   logic                      oobx_c;
   logic                      ooby_c;
   logic                      load_c;

   // The ROM address is the position counter itself.
   assign rom_a = cnt;

   // Output register accepts a new sample when empty or being drained this cycle.
   assign load_c = (state == SCAN) && (!out_valid || out_ready);

   desc_coord_add #(.LIMIT(IMG_W)) u_add_x (
      .kp    (kx),
      .off   (rom_x_spo),
      .sum_c (sx_c),
      .oob_c (oobx_c)
   );

   desc_coord_add #(.LIMIT(IMG_H)) u_add_y (
      .kp    (ky),
      .off   (rom_y_spo),
      .sum_c (sy_c),
      .oob_c (ooby_c)
   );

   // Scan control: latch keypoint, step positions under back-pressure, drain final sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         kx        <= '0;
         ky        <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         smp_q     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  kx    <= kp_x;
                  ky    <= kp_y;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (load_c) begin
                  out_valid <= 1'b1;
                  smp_q     <= '{x: sx_c, y: sy_c, idx: cnt,
                                 oob: oobx_c | ooby_c, last: (cnt == LAST_IDX)};
                  if (cnt == LAST_IDX) begin
                     state <= DRAIN;
                  end else begin
                     cnt <= cnt + IDX_W'(1);
                  end
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_x    = smp_q.x;
   assign out_y    = smp_q.y;
   assign out_idx  = smp_q.idx;
   assign out_oob  = smp_q.oob;
   assign out_last = smp_q.last;

endmodule
